control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Multi-cycle RV32I main controller: decodes op/funct fields from the instruction register, sequences
//  FETCH..WRITEBACK states, drives datapath enables/muxes, and produces ImmSrc for the sign extender
//  directly downstream. ImmSrc is 3 bits; encoding 0=I, 1=S, 2=B, 3=U, 4=J; sign extender port widens to match.
// PARAMETERS
//  IMM_SRC_W   3   ImmSrc width; must be >=3 to encode J-type (4)
//  ALU_CTRL_W  3   ALUControl width
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst         in   1   synchronous, active-high reset
//  op          in   7   instr[6:0]
//  funct3      in   3   instr[14:12]
//  funct7b5    in   1   instr[30]
//  Zero        in   1   ALU zero flag
//  PCWrite     out  1   PC register enable
//  AdrSrc      out  1   memory address mux: 0=PC, 1=ALUOut
//  MemWrite    out  1   data memory write enable
//  IRWrite     out  1   instruction register + OldPC enable
//  RegWrite    out  1   register file write enable
//  ResultSrc   out  2   00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  2   00=PC, 01=OldPC, 10=rs1(A), 11=zero
//  ALUSrcB     out  2   00=rs2(WD), 01=ImmExt, 10=const 4
//  ALUControl  out  3   000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc      out  3   immediate format to sign extender
//  state_o     out  4   current state (debug)
//  illegal_op  out  1   sticky illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - State encoding: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECUTER=6 EXECUTEI=7
//    ALUWB=8 BEQ=9 JAL=10 LUI=11 TRAP=12; codes 13-15 unreachable, map to FETCH next cycle.
//  - Reset: state<=FETCH; while rst=1 PCWrite/MemWrite/IRWrite/RegWrite=0, illegal_op cleared.
//    Reset mid-instruction abandons it; first cycle after rst deasserts is FETCH.
//  - Outputs Moore from state; ImmSrc combinational from op only (valid in every state):
//    0000011/0010011/1100111->0, 0100011->1, 1100011->2, 0110111->3, 1101111->4, other->0.
//  - FETCH: AdrSrc=0 IRWrite=1 SrcA=00 SrcB=10 add ResultSrc=10 PCWrite=1 -> DECODE.
//  - DECODE: SrcA=01 SrcB=01 add (branch target into ALUOut). Next by op: 0000011/0100011->MEMADR,
//    0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, 0110111->LUI, other->FETCH.
//  - MEMADR: SrcA=10 SrcB=01 add; op[5]=0 ->MEMREAD, 1 ->MEMWRITE.
//  - MEMREAD: AdrSrc=1 ResultSrc=00 -> MEMWB.  MEMWB: ResultSrc=01 RegWrite=1 -> FETCH.
//  - MEMWRITE: AdrSrc=1 ResultSrc=00 MemWrite=1 -> FETCH.
//  - EXECUTER: SrcA=10 SrcB=00 ALU by funct -> ALUWB.  EXECUTEI: SrcA=10 SrcB=01 ALU by funct -> ALUWB.
//  - LUI: SrcA=11 SrcB=01 add -> ALUWB.  ALUWB: ResultSrc=00 RegWrite=1 -> FETCH.
//  - JAL: SrcA=01 SrcB=10 add ResultSrc=00 PCWrite=1 (PC<=target, ALUResult=OldPC+4) -> ALUWB.
//  - BEQ: SrcA=10 SrcB=00 sub ResultSrc=00; PCWrite=Zero -> FETCH.
//  - ALU by funct (EXECUTER/EXECUTEI): funct3 000 -> sub iff funct7b5&op[5] (R-type) else add;
//    010 slt, 110 or, 111 and, other -> add.
//  - Latency (cycles incl. FETCH): lw 5, sw 4, R/I/lui 4, jal 4, beq 3.
//  - Unused mux selects in a state are 00; only listed enables are 1.
// CONFIGURATION
//  ILLEGAL_OP_TRAP_EN defined: unrecognised op in DECODE -> TRAP; TRAP holds all enables 0,
//   illegal_op=1, exits only via rst.
//  Not defined: unrecognised op -> FETCH (executes as NOP, PC already +4); TRAP absent; illegal_op tied 0.
// TESTING
//  - rst=1 2 cycles then op=0000011 (lw) -> state_o 0,1,2,3,4,0; RegWrite=1 only in state 4; ImmSrc=0.
//  - op=0100011 (sw) -> states 0,1,2,5,0; MemWrite=1 only in 5, AdrSrc=1 in 5; ImmSrc=1.
//  - op=0110011 funct3=000 funct7b5=1 -> EXECUTER ALUControl=001; same with op=0010011 -> 000.
//  - op=1100011, Zero=1 then Zero=0 -> BEQ PCWrite=1 / 0; ImmSrc=2; op=1101111 -> ImmSrc=4, JAL PCWrite=1.
//  - Assert rst during MEMREAD -> next cycle state_o=0, no RegWrite pulse.
//  - op=1111111: with ILLEGAL_OP_TRAP_EN -> state 12, illegal_op=1 held 10 cycles; without -> FETCH.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I main controller.
// Sequences FETCH..WRITEBACK, drives datapath enables/mux selects (Moore),
// and decodes ImmSrc combinationally from op for the sign extender.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unknown opcodes park in TRAP).
module control_fsm #(
    parameter int IMM_SRC_W  = 3,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  Zero,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [IMM_SRC_W-1:0]  ImmSrc,
    output logic [3:0]            state_o,
    output logic                  illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(5);

    typedef struct packed {
        logic                  pc_write;
        logic                  adr_src;
        logic                  mem_write;
        logic                  ir_write;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic [1:0]            src_a;
        logic [1:0]            src_b;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
    } ctrl_t;

    state_t                state, state_nx;
    ctrl_t                 ctrl;
    logic [ALU_CTRL_W-1:0] alu_funct;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    // ALU operation for EXECUTER/EXECUTEI; sub only for R-type (op[5]=1) with funct7b5.
    always_comb begin
        alu_funct = ALU_ADD;
        case (funct3)
            3'b000:  alu_funct = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    // Next-state and Moore control outputs; all selects/enables default to 0.
    always_comb begin
        state_nx = S_FETCH;
        ctrl     = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.src_b      = 2'b10;
                ctrl.result_src = 2'b10;
                ctrl.pc_write   = 1'b1;
                state_nx        = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut for a possible branch.
                ctrl.src_a = 2'b01;
                ctrl.src_b = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_nx = S_MEMADR;
                    7'b0110011:             state_nx = S_EXECUTER;
                    7'b0010011:             state_nx = S_EXECUTEI;
                    7'b1100011:             state_nx = S_BEQ;
                    7'b1101111:             state_nx = S_JAL;
                    7'b0110111:             state_nx = S_LUI;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                state_nx = S_TRAP;
`else
                    default:                state_nx = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ctrl.src_a = 2'b10;
                ctrl.src_b = 2'b01;
                state_nx   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                state_nx     = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                state_nx        = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                state_nx       = S_FETCH;
            end
            S_EXECUTER: begin
                ctrl.src_a    = 2'b10;
                ctrl.alu_ctrl = alu_funct;
                state_nx      = S_ALUWB;
            end
            S_EXECUTEI: begin
                ctrl.src_a    = 2'b10;
                ctrl.src_b    = 2'b01;
                ctrl.alu_ctrl = alu_funct;
                state_nx      = S_ALUWB;
            end
            S_LUI: begin
                ctrl.src_a = 2'b11;
                ctrl.src_b = 2'b01;
                state_nx   = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                state_nx       = S_FETCH;
            end
            S_JAL: begin
                // PC <= target from ALUOut; ALUResult = OldPC+4 is the link value.
                ctrl.src_a    = 2'b01;
                ctrl.src_b    = 2'b10;
                ctrl.pc_write = 1'b1;
                state_nx      = S_ALUWB;
            end
            S_BEQ: begin
                ctrl.src_a    = 2'b10;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.pc_write = Zero;
                state_nx      = S_FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: state_nx = S_TRAP;
`endif
            default: state_nx = S_FETCH;
        endcase
    end

    // Immediate format depends only on op so the extender is valid in every state.
    always_comb begin
        ImmSrc = IMM_SRC_W'(0);
        case (op)
            7'b0100011: ImmSrc = IMM_SRC_W'(1);
            7'b1100011: ImmSrc = IMM_SRC_W'(2);
            7'b0110111: ImmSrc = IMM_SRC_W'(3);
            7'b1101111: ImmSrc = IMM_SRC_W'(4);
            default:    ImmSrc = IMM_SRC_W'(0);
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    // Sticky flag raised on entry to TRAP; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)                     illegal_q <= 1'b0;
        else if (state_nx == S_TRAP) illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q & ~rst;
`else
    assign illegal_op = 1'b0;
`endif

    // Enables are forced low for the whole reset window, including the FETCH state it loads.
    assign PCWrite    = ctrl.pc_write  & ~rst;
    assign MemWrite   = ctrl.mem_write & ~rst;
    assign IRWrite    = ctrl.ir_write  & ~rst;
    assign RegWrite   = ctrl.reg_write & ~rst;
    assign AdrSrc     = ctrl.adr_src;
    assign ResultSrc  = ctrl.result_src;
    assign ALUSrcA    = ctrl.src_a;
    assign ALUSrcB    = ctrl.src_b;
    assign ALUControl = ctrl.alu_ctrl;
    assign state_o    = state;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench for control_fsm. Tasks push expected
// per-cycle controls when driving an instruction; a negedge monitor pops
// and compares them against the DUT.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [3:0] st;
        logic       pcw, adr, memw, irw, regw, ill;
        logic [1:0] rsrc, srca, srcb;
        logic [2:0] aluc, imm;
    } exp_t;

    exp_t sb[$];

    control_fsm #(.IMM_SRC_W(3), .ALU_CTRL_W(3)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .state_o(state_o), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Reference control table: what each state must drive. aluc_x is the
    // hand-derived ALU op for the execute states, imm the hand-derived ImmSrc.
    function automatic exp_t expect_for(string nm, logic [3:0] st, logic z,
                                        logic [2:0] aluc_x, logic [2:0] imm);
        exp_t e;
        e.nm = nm; e.st = st; e.imm = imm;
        e.pcw = 0; e.adr = 0; e.memw = 0; e.irw = 0; e.regw = 0; e.ill = 0;
        e.rsrc = 0; e.srca = 0; e.srcb = 0; e.aluc = 0;
        case (st)
            4'd0:  begin e.irw = 1; e.pcw = 1; e.srcb = 2'b10; e.rsrc = 2'b10; end
            4'd1:  begin e.srca = 2'b01; e.srcb = 2'b01; end
            4'd2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
            4'd3:  e.adr = 1;
            4'd4:  begin e.rsrc = 2'b01; e.regw = 1; end
            4'd5:  begin e.adr = 1; e.memw = 1; end
            4'd6:  begin e.srca = 2'b10; e.aluc = aluc_x; end
            4'd7:  begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = aluc_x; end
            4'd8:  e.regw = 1;
            4'd9:  begin e.srca = 2'b10; e.aluc = 3'b001; e.pcw = z; end
            4'd10: begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
            4'd11: begin e.srca = 2'b11; e.srcb = 2'b01; end
            4'd12: e.ill = 1;
            default: ;
        endcase
        return e;
    endfunction

    // Scoreboard monitor: one expected record per non-reset cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            checks += 11;
            if (state_o    !== e.st)   begin errors++; $display("FAIL %s state: got %0d want %0d", e.nm, state_o, e.st); end
            if (PCWrite    !== e.pcw)  begin errors++; $display("FAIL %s st%0d PCWrite: got %b want %b", e.nm, e.st, PCWrite, e.pcw); end
            if (AdrSrc     !== e.adr)  begin errors++; $display("FAIL %s st%0d AdrSrc: got %b want %b", e.nm, e.st, AdrSrc, e.adr); end
            if (MemWrite   !== e.memw) begin errors++; $display("FAIL %s st%0d MemWrite: got %b want %b", e.nm, e.st, MemWrite, e.memw); end
            if (IRWrite    !== e.irw)  begin errors++; $display("FAIL %s st%0d IRWrite: got %b want %b", e.nm, e.st, IRWrite, e.irw); end
            if (RegWrite   !== e.regw) begin errors++; $display("FAIL %s st%0d RegWrite: got %b want %b", e.nm, e.st, RegWrite, e.regw); end
            if (ResultSrc  !== e.rsrc) begin errors++; $display("FAIL %s st%0d ResultSrc: got %b want %b", e.nm, e.st, ResultSrc, e.rsrc); end
            if (ALUSrcA    !== e.srca) begin errors++; $display("FAIL %s st%0d ALUSrcA: got %b want %b", e.nm, e.st, ALUSrcA, e.srca); end
            if (ALUSrcB    !== e.srcb) begin errors++; $display("FAIL %s st%0d ALUSrcB: got %b want %b", e.nm, e.st, ALUSrcB, e.srcb); end
            if (ALUControl !== e.aluc) begin errors++; $display("FAIL %s st%0d ALUControl: got %b want %b", e.nm, e.st, ALUControl, e.aluc); end
            if ({ImmSrc, illegal_op} !== {e.imm, e.ill}) begin
                errors++;
                $display("FAIL %s st%0d ImmSrc/illegal_op: got %0d/%b want %0d/%b", e.nm, e.st, ImmSrc, illegal_op, e.imm, e.ill);
            end
        end
    end

    // Drive one instruction starting in FETCH; seq holds the expected states,
    // first state in the lowest nibble. Returns just after the edge back to FETCH.
    task automatic run_instr(string nm, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                             logic [47:0] seq, int n, logic [2:0] aluc, logic [2:0] imm);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        for (int i = 0; i < n; i++) sb.push_back(expect_for(nm, seq[4*i +: 4], z, aluc, imm));
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (state_o !== 4'd0) begin errors++; $display("FAIL reset state: got %0d want 0", state_o); end
        if ({PCWrite, MemWrite, IRWrite, RegWrite, illegal_op} !== 5'b0) begin
            errors++;
            $display("FAIL reset enables: got %b want 00000", {PCWrite, MemWrite, IRWrite, RegWrite, illegal_op});
        end
        rst = 1'b0;
    endtask

    task automatic test_mem();
        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 48'h43210, 5, 3'b000, 3'd0);
        run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 48'h5210,  4, 3'b000, 3'd1);
    endtask

    task automatic test_alu();
        run_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 48'h8610, 4, 3'b001, 3'd0);
        run_instr("r_add", 7'b0110011, 3'b000, 1'b0, 1'b0, 48'h8610, 4, 3'b000, 3'd0);
        run_instr("r_and", 7'b0110011, 3'b111, 1'b0, 1'b0, 48'h8610, 4, 3'b010, 3'd0);
        run_instr("r_or",  7'b0110011, 3'b110, 1'b0, 1'b0, 48'h8610, 4, 3'b011, 3'd0);
        run_instr("r_slt", 7'b0110011, 3'b010, 1'b0, 1'b0, 48'h8610, 4, 3'b101, 3'd0);
        run_instr("r_xor", 7'b0110011, 3'b100, 1'b1, 1'b0, 48'h8610, 4, 3'b000, 3'd0);
        run_instr("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 48'h8710, 4, 3'b000, 3'd0);
        run_instr("andi",  7'b0010011, 3'b111, 1'b0, 1'b0, 48'h8710, 4, 3'b010, 3'd0);
    endtask

    task automatic test_branch_jump();
        run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 48'h910,  3, 3'b000, 3'd2);
        run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 48'h910,  3, 3'b000, 3'd2);
        run_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 48'h8A10, 4, 3'b000, 3'd4);
        run_instr("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, 48'h8B10, 4, 3'b000, 3'd3);
    endtask

    task automatic test_reset_midinstr();
        // lw through FETCH, DECODE, MEMADR; reset lands while in MEMREAD.
        run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 48'h210, 3, 3'b000, 3'd0);
        checks++;
        if (state_o !== 4'd3) begin errors++; $display("FAIL midreset pre-state: got %0d want 3", state_o); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (state_o !== 4'd0) begin errors++; $display("FAIL midreset state: got %0d want 0", state_o); end
        if (RegWrite !== 1'b0) begin errors++; $display("FAIL midreset RegWrite: got %b want 0", RegWrite); end
        rst = 1'b0;
        // Full lw after the abort must still work from FETCH.
        run_instr("lw_after", 7'b0000011, 3'b010, 1'b0, 1'b0, 48'h43210, 5, 3'b000, 3'd0);
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_OP_TRAP_EN
        run_instr("trap", 7'b1111111, 3'b000, 1'b0, 1'b0, 48'hCCCCCCCCCC10, 12, 3'b000, 3'd0);
        checks += 2;
        if (state_o !== 4'd12) begin errors++; $display("FAIL trap hold state: got %0d want 12", state_o); end
        if (illegal_op !== 1'b1) begin errors++; $display("FAIL trap illegal_op: got %b want 1", illegal_op); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (state_o !== 4'd0) begin errors++; $display("FAIL trap exit state: got %0d want 0", state_o); end
        if (illegal_op !== 1'b0) begin errors++; $display("FAIL trap exit illegal_op: got %b want 0", illegal_op); end
        rst = 1'b0;
`else
        run_instr("nop_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 48'h10, 2, 3'b000, 3'd0);
        checks += 2;
        if (state_o !== 4'd0) begin errors++; $display("FAIL illegal op next state: got %0d want 0", state_o); end
        if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_op tie: got %b want 0", illegal_op); end
`endif
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_sw",  7'b0100011, 3'b010, 1'b0, 1'b0, 48'h5210,  4, 3'b000, 3'd1);
        run_instr("b2b_beq", 7'b1100011, 3'b000, 1'b0, 1'b1, 48'h910,   3, 3'b000, 3'd2);
        run_instr("b2b_lw",  7'b0000011, 3'b010, 1'b0, 1'b0, 48'h43210, 5, 3'b000, 3'd0);
        run_instr("b2b_sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 48'h8610,  4, 3'b001, 3'd0);
    endtask

    initial begin
        test_reset();
        test_mem();
        test_alu();
        test_branch_jump();
        test_reset_midinstr();
        test_illegal();
        test_back_to_back();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard drain: got %0d left want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
